// File: rtl/descrambler.sv
// Two-lane 8b symbol descrambler with SR-based keystream resync and SR-spacing lock tracking.
// The keystream is the X^16+X^5+X^4+X^3+1 LFSR, seeded 0xFFFF, stepped 8 bits per symbol.
module descrambler #(
  parameter int unsigned SR_PERIOD = 512,
  parameter int unsigned LOCK_SR   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] indata,
  input  logic [1:0]  inisk,
  output logic [15:0] outdata,
  output logic [1:0]  outisk,
  output logic        locked,
  output logic        sr_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned GOOD_W = (LOCK_SR < 2) ? 1 : $clog2(LOCK_SR + 1);
  localparam logic [CNT_W-1:0]  BS_LAST   = CNT_W'(SR_PERIOD - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_SR - 1);
  localparam logic [7:0]  K_BS = 8'hBC;
  localparam logic [7:0]  K_SR = 8'h1C;
  localparam logic [15:0] SEED = 16'hFFFF;
  localparam logic [15:0] TAPS = 16'h0039;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    bs_cnt_q, bs_cnt_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [15:0]         outdata_q, outdata_d;
  logic [1:0]          outisk_q;
  logic                locked_q, locked_d;
  logic                sr_err_q, sr_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [1:0]          is_sr, is_bs;
  logic [15:0]         lane1_state;
  logic [7:0]          key0, key1;
  logic                sr_evt, sr_good, sr_missing;

  // Eight serial LFSR steps (MSB shifted out, taps folded back in).
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[14:0], 1'b0} ^ ({16{t[15]}} & TAPS);
    end
    return t;
  endfunction

  // The 8 key bits are the top byte shifted out MSB first, landing on symbol bit 0 first.
  function automatic logic [7:0] lfsr_key(input logic [15:0] s);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[15-i];
    end
    return k;
  endfunction

  // Keystream, lane decode, symbol replacement and BS-slot counting.
  always_comb begin
    is_sr       = '0;
    is_bs       = '0;
    lane1_state = SEED;
    key0        = '0;
    key1        = '0;
    lfsr_d      = lfsr_q;
    outdata_d   = '0;
    sr_evt      = 1'b0;
    sr_good     = 1'b0;
    sr_missing  = 1'b0;
    bs_cnt_d    = bs_cnt_q;

    is_sr[0] = inisk[0] && (indata[7:0]  == K_SR);
    is_sr[1] = inisk[1] && (indata[15:8] == K_SR);
    is_bs[0] = inisk[0] && (indata[7:0]  == K_BS);
    is_bs[1] = inisk[1] && (indata[15:8] == K_BS);

    key0        = lfsr_key(lfsr_q);
    lane1_state = is_sr[0] ? SEED : lfsr_adv8(lfsr_q);
    key1        = lfsr_key(lane1_state);
    lfsr_d      = is_sr[1] ? SEED : lfsr_adv8(lane1_state);

    outdata_d[7:0]  = is_sr[0] ? K_BS : (inisk[0] ? indata[7:0]  : (indata[7:0]  ^ key0));
    outdata_d[15:8] = is_sr[1] ? K_BS : (inisk[1] ? indata[15:8] : (indata[15:8] ^ key1));

    // Walk lanes in time order; the earliest SR of the cycle decides spacing.
    for (int l = 0; l < 2; l++) begin
      if (is_sr[l]) begin
        if (!sr_evt) begin
          sr_evt  = 1'b1;
          sr_good = (bs_cnt_d == BS_LAST);
        end
        bs_cnt_d = '0;
      end else if (is_bs[l]) begin
        if (bs_cnt_d == BS_LAST) begin
          sr_missing = 1'b1;
          bs_cnt_d   = '0;
        end else begin
          bs_cnt_d = bs_cnt_d + CNT_W'(1);
        end
      end
    end
  end

  // Lock FSM next-state, error pulse and saturating error count.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    sr_err_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    locked_d  = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (sr_evt) begin
          state_d = CHECK;
          good_d  = GOOD_W'(1);
        end
      end
      CHECK: begin
        if (sr_evt) begin
          if (sr_good) begin
            if (good_q >= GOOD_LAST) begin
              state_d = LOCKED;
              good_d  = GOOD_W'(LOCK_SR);
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            good_d = GOOD_W'(1);
          end
        end else if (sr_missing) begin
          state_d = HUNT;
          good_d  = '0;
        end
      end
      LOCKED: begin
        if (sr_evt) begin
          if (!sr_good) begin
            state_d  = CHECK;
            good_d   = GOOD_W'(1);
            sr_err_d = 1'b1;
          end
        end else if (sr_missing) begin
          state_d  = HUNT;
          good_d   = '0;
          sr_err_d = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        good_d  = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);
    if (sr_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers; reset overrides any event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      lfsr_q    <= SEED;
      bs_cnt_q  <= '0;
      good_q    <= '0;
      outdata_q <= '0;
      outisk_q  <= '0;
      locked_q  <= 1'b0;
      sr_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      bs_cnt_q  <= bs_cnt_d;
      good_q    <= good_d;
      outdata_q <= outdata_d;
      outisk_q  <= inisk;
      locked_q  <= locked_d;
      sr_err_q  <= sr_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign outdata = outdata_q;
  assign outisk  = outisk_q;
  assign locked  = locked_q;
  assign sr_err  = sr_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_descrambler.sv
// Directed bench for descrambler: default-period instance plus a short-period instance for saturation.
module tb_descrambler;

  logic        clk;
  logic        reset;
  logic [15:0] indata;
  logic [1:0]  inisk;

  logic [15:0] outdata,  outdata2;
  logic [1:0]  outisk,   outisk2;
  logic        locked,   locked2;
  logic        sr_err,   sr_err2;
  logic [7:0]  err_cnt,  err_cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       k;
    logic [7:0] d;
  } sym_t;

  descrambler dut (
    .clk(clk), .reset(reset), .indata(indata), .inisk(inisk),
    .outdata(outdata), .outisk(outisk), .locked(locked),
    .sr_err(sr_err), .err_cnt(err_cnt)
  );

  descrambler #(.SR_PERIOD(8), .LOCK_SR(2)) dut2 (
    .clk(clk), .reset(reset), .indata(indata), .inisk(inisk),
    .outdata(outdata2), .outisk(outisk2), .locked(locked2),
    .sr_err(sr_err2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and return 1ns after the capturing edge.
  task automatic cyc(input logic [15:0] d, input logic [1:0] k);
    indata = d;
    inisk  = k;
    @(posedge clk);
    #1;
  endtask

  sym_t        plain_q[$];
  sym_t        tx_q[$];
  int          sr_seen;
  int          sr2_cycle;
  logic [15:0] tx_lfsr;
  logic [7:0]  kbyte;
  logic        b;
  sym_t        s;
  logic [7:0]  e0, e1;
  int          pulses;
  int          ncyc;

  initial begin
    reset  = 1'b1;
    indata = '0;
    inisk  = '0;

    // Reset state
    cyc(16'h0000, 2'b00);
    cyc(16'h0000, 2'b00);
    chk("rst_outdata", 32'(outdata), 32'h0);
    chk("rst_outisk",  32'(outisk),  32'h0);
    chk("rst_locked",  32'(locked),  32'h0);
    chk("rst_sr_err",  32'(sr_err),  32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    reset = 1'b0;

    // SR in lane 0 reseeds lane 1 to key 0xFF, then keys continue 0x17, 0xC0
    cyc(16'h001C, 2'b01);
    chk("sr0_outdata", 32'(outdata), 32'hFFBC);
    chk("sr0_outisk",  32'(outisk),  32'h1);
    cyc(16'h0000, 2'b00);
    chk("sr0_next_lane0", 32'(outdata[7:0]), 32'h17);
    chk("sr0_next_full",  32'(outdata),      32'hC017);
    chk("sr0_next_outisk", 32'(outisk),      32'h0);

    // SR in lane 1: lane 0 keeps the free-running key, next cycle starts at 0xFFFF
    reset = 1'b1;
    cyc(16'h0000, 2'b00);
    reset = 1'b0;
    cyc(16'h1C00, 2'b10);
    chk("sr1_lane1", 32'(outdata[15:8]), 32'hBC);
    chk("sr1_full",  32'(outdata),       32'hBCFF);
    cyc(16'h0000, 2'b00);
    chk("sr1_next", 32'(outdata), 32'h17FF);

    // Non-SR control symbol passes but still consumes keystream
    reset = 1'b1;
    cyc(16'h0000, 2'b00);
    reset = 1'b0;
    cyc(16'h003C, 2'b01);
    chk("ctrl_pass", 32'(outdata), 32'h173C);
    cyc(16'h5AA5, 2'b00);
    chk("ctrl_next", 32'(outdata), 32'h4E65);

    // Looped transmit scrambler stream, SR_PERIOD 512
    reset = 1'b1;
    cyc(16'h0000, 2'b00);
    reset = 1'b0;
    sr_seen   = 0;
    sr2_cycle = -1;
    for (int i = 0; i < 3; i++) plain_q.push_back({1'b0, 8'($urandom_range(0, 255))});
    for (int p = 0; p < 3; p++) begin
      plain_q.push_back({1'b1, 8'h1C});
      sr_seen++;
      if (sr_seen == 2) sr2_cycle = (plain_q.size() - 1) / 2;
      for (int n = 0; n < 511; n++) begin
        plain_q.push_back({1'b1, 8'hBC});
        if ($urandom_range(0, 3) == 0) plain_q.push_back({1'b0, 8'($urandom_range(0, 255))});
      end
    end
    plain_q.push_back({1'b1, 8'h1C});
    for (int i = 0; i < 5; i++) plain_q.push_back({1'b0, 8'($urandom_range(0, 255))});
    if (plain_q.size() % 2 != 0) plain_q.push_back({1'b0, 8'h5A});

    tx_lfsr = 16'hFFFF;
    foreach (plain_q[i]) begin
      s = plain_q[i];
      if (s.k && s.d == 8'h1C) begin
        tx_q.push_back(s);
        tx_lfsr = 16'hFFFF;
      end else begin
        kbyte = '0;
        for (int j = 0; j < 8; j++) begin
          b        = tx_lfsr[15];
          kbyte[j] = b;
          tx_lfsr  = {tx_lfsr[14:0], 1'b0} ^ (b ? 16'h0039 : 16'h0000);
        end
        tx_q.push_back({s.k, s.k ? s.d : (s.d ^ kbyte)});
      end
    end

    ncyc = tx_q.size() / 2;
    for (int c = 0; c < ncyc; c++) begin
      cyc({tx_q[2*c+1].d, tx_q[2*c].d}, {tx_q[2*c+1].k, tx_q[2*c].k});
      e0 = (plain_q[2*c].k   && plain_q[2*c].d   == 8'h1C) ? 8'hBC : plain_q[2*c].d;
      e1 = (plain_q[2*c+1].k && plain_q[2*c+1].d == 8'h1C) ? 8'hBC : plain_q[2*c+1].d;
      chk($sformatf("loop_data[%0d]", c), 32'(outdata), 32'({e1, e0}));
      chk($sformatf("loop_isk[%0d]", c), 32'(outisk), 32'({plain_q[2*c+1].k, plain_q[2*c].k}));
      chk($sformatf("loop_locked[%0d]", c), 32'(locked), (c >= sr2_cycle) ? 32'h1 : 32'h0);
    end

    // Lock, then an SR at bs_cnt 300
    reset = 1'b1;
    cyc(16'h0000, 2'b00);
    reset = 1'b0;
    cyc(16'hBC1C, 2'b11);
    chk("lk_first_sr", 32'(locked), 32'h0);
    repeat (255) cyc(16'hBCBC, 2'b11);
    cyc(16'hBC1C, 2'b11);
    chk("lk_locked", 32'(locked), 32'h1);
    repeat (149) cyc(16'hBCBC, 2'b11);
    cyc(16'h1CBC, 2'b11);
    chk("mis_sr_err",  32'(sr_err),  32'h1);
    chk("mis_err_cnt", 32'(err_cnt), 32'h1);
    chk("mis_locked",  32'(locked),  32'h0);
    chk("mis_outdata", 32'(outdata), 32'hBCBC);
    cyc(16'h0000, 2'b00);
    chk("mis_pulse_end", 32'(sr_err), 32'h0);
    // One correctly spaced SR relocks, so the misspaced SR left the FSM in CHECK
    repeat (255) cyc(16'hBCBC, 2'b11);
    cyc(16'h1CBC, 2'b11);
    chk("relock_locked", 32'(locked), 32'h1);
    chk("relock_no_err", 32'(sr_err), 32'h0);

    // 512 BS with no SR
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(16'hBCBC, 2'b11);
      if (sr_err) pulses++;
    end
    chk("miss_early_pulses", 32'(pulses), 32'h0);
    chk("miss_still_locked", 32'(locked), 32'h1);
    cyc(16'hBCBC, 2'b11);
    chk("miss_sr_err",  32'(sr_err),  32'h1);
    chk("miss_locked",  32'(locked),  32'h0);
    chk("miss_err_cnt", 32'(err_cnt), 32'h2);
    cyc(16'hBC1C, 2'b11);
    chk("hunt_first_sr_locked", 32'(locked), 32'h0);
    chk("hunt_first_sr_err",    32'(sr_err), 32'h0);

    // Saturation on the short-period instance
    reset = 1'b1;
    cyc(16'h0000, 2'b00);
    reset = 1'b0;
    cyc(16'hBC1C, 2'b11);
    repeat (3) cyc(16'hBCBC, 2'b11);
    cyc(16'hBC1C, 2'b11);
    chk("sat_lock", 32'(locked2), 32'h1);
    for (int i = 1; i <= 300; i++) begin
      cyc(16'hBC1C, 2'b11);
      chk($sformatf("sat_err[%0d]", i), 32'(sr_err2), 32'h1);
      chk($sformatf("sat_cnt[%0d]", i), 32'(err_cnt2), (i > 255) ? 32'd255 : 32'(i));
      repeat (3) cyc(16'hBCBC, 2'b11);
      cyc(16'hBC1C, 2'b11);
      chk($sformatf("sat_relock[%0d]", i), 32'(locked2), 32'h1);
    end

    // Reset while locked, with an SR present in the same cycle
    reset = 1'b1;
    cyc(16'hBC1C, 2'b11);
    chk("rl_outdata", 32'(outdata2), 32'h0);
    chk("rl_outisk",  32'(outisk2),  32'h0);
    chk("rl_locked",  32'(locked2),  32'h0);
    chk("rl_sr_err",  32'(sr_err2),  32'h0);
    chk("rl_err_cnt", 32'(err_cnt2), 32'h0);
    reset = 1'b0;
    cyc(16'h0000, 2'b00);
    chk("rl_lfsr_restart", 32'(outdata2), 32'h17FF);
    chk("rl_still_unlocked", 32'(locked2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
